// File: rtl/pipe_pkg.sv
// Shared definitions for the 5-stage pipeline control: FSM encoding,
// EX_MEM MEM control bit positions and the hard-wired zero register.
package pipe_pkg;

    typedef enum logic [1:0] {
        INIT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    localparam int unsigned MEMRD = 1;
    localparam int unsigned MEMWR = 0;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline hazard inputs, data-memory handshake,
// stage enables/flushes and status. master = controller, slave = pipeline.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             idex_memrd;
    logic [4:0]       idex_wn;
    logic             br_taken;
    logic [1:0]       exmem_mem;
    logic             dmem_ack;
    logic             dmem_req;
    logic             en_pc;
    logic             en_ifid;
    logic             en_idex;
    logic             en_exmem;
    logic             en_memwb;
    logic             flush_ifid;
    logic             flush_idex;
    logic [CNT_W-1:0] stall_cnt;
    logic             mem_err;

    modport master (
        input  id_rs, id_rt, id_uses_rt, idex_memrd, idex_wn, br_taken,
               exmem_mem, dmem_ack,
        output dmem_req, en_pc, en_ifid, en_idex, en_exmem, en_memwb,
               flush_ifid, flush_idex, stall_cnt, mem_err
    );

    modport slave (
        output id_rs, id_rt, id_uses_rt, idex_memrd, idex_wn, br_taken,
               exmem_mem, dmem_ack,
        input  dmem_req, en_pc, en_ifid, en_idex, en_exmem, en_memwb,
               flush_ifid, flush_idex, stall_cnt, mem_err
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment)
// and asynchronous active-low reset.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline: load-use bubbles,
// taken-branch flushes and multi-cycle data-memory stalls.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.master bus
);

    localparam int unsigned WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        WAIT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_err;

    logic mem_op;
    logic load_use;
    logic timeout;
    logic pipe_go;
    logic dmem_req;
    logic en_pc, en_ifid, en_idex, en_exmem, en_memwb;
    logic flush_ifid, flush_idex;

    // pipe_go: the memory stage is not holding the pipe this cycle, so the
    // branch/load-use rules decide the enables.
    always_comb begin
        mem_op   = bus.exmem_mem[MEMRD] | bus.exmem_mem[MEMWR];
        load_use = bus.idex_memrd && (bus.idex_wn != REG_ZERO) &&
                   ((bus.idex_wn == bus.id_rs) ||
                    (bus.id_uses_rt && (bus.idex_wn == bus.id_rt)));
        timeout  = (TIMEOUT != 0) && (state == MEM_WAIT) && !bus.dmem_ack &&
                   (wait_cnt == WAIT_LAST);

        pipe_go  = 1'b0;
        dmem_req = 1'b0;
        case (state)
            RUN: begin
                dmem_req = mem_op;
                pipe_go  = !mem_op || bus.dmem_ack;
            end
            MEM_WAIT: begin
                dmem_req = !timeout;
                pipe_go  = bus.dmem_ack || timeout;
            end
            default: begin
                dmem_req = 1'b0;
                pipe_go  = 1'b0;
            end
        endcase

        en_pc      = pipe_go;
        en_ifid    = pipe_go;
        en_idex    = pipe_go;
        en_exmem   = pipe_go;
        en_memwb   = pipe_go;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;
        if (pipe_go) begin
            if (bus.br_taken) begin
                flush_ifid = 1'b1;
                flush_idex = 1'b1;
            end else if (load_use) begin
                en_pc      = 1'b0;
                en_ifid    = 1'b0;
                flush_idex = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= INIT;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            case (state)
                INIT: state <= RUN;
                RUN: begin
                    if (mem_op && !bus.dmem_ack) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (bus.dmem_ack || timeout) begin
                        state <= RUN;
                        if (timeout) mem_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc ((state != INIT) && !en_pc),
        .clr (1'b0),
        .cnt (bus.stall_cnt)
    );

    assign bus.dmem_req   = dmem_req;
    assign bus.en_pc      = en_pc;
    assign bus.en_ifid    = en_ifid;
    assign bus.en_idex    = en_idex;
    assign bus.en_exmem   = en_exmem;
    assign bus.en_memwb   = en_memwb;
    assign bus.flush_ifid = flush_ifid;
    assign bus.flush_idex = flush_idex;
    assign bus.mem_err    = mem_err;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed vector bench for pipe_hazard_ctrl (TIMEOUT=4) plus a small
// saturation check of sat_counter.
module tb_pipe_hazard_ctrl;

    localparam int unsigned CNT_W = 16;

    // {dmem_req, en_pc, en_ifid, en_idex, en_exmem, en_memwb, flush_ifid, flush_idex}
    localparam logic [7:0] O_IDLE = 8'b0_00000_00;
    localparam logic [7:0] O_FREE = 8'b0_11111_00;
    localparam logic [7:0] O_LU   = 8'b0_00111_01;
    localparam logic [7:0] O_BR   = 8'b0_11111_11;
    localparam logic [7:0] O_MSTL = 8'b1_00000_00;
    localparam logic [7:0] O_ZW   = 8'b1_11111_00;
    localparam logic [7:0] O_ZWBR = 8'b1_11111_11;

    typedef struct {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        ut;
        logic        memrd;
        logic [4:0]  wn;
        logic        br;
        logic [1:0]  mem;
        logic        ack;
        logic [7:0]  exp_out;
        logic [15:0] exp_cnt;
        logic        exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic       sc_inc = 1'b0;
    logic       sc_clr = 1'b0;
    logic [1:0] sc_cnt;

    int nvec = 0;
    int nerr = 0;

    vec_t vt[25];

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipe_hazard_ctrl #(
        .TIMEOUT (4),
        .CNT_W   (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    sat_counter #(.CNT_W(2)) u_sc (
        .clk (clk),
        .rst (rst),
        .inc (sc_inc),
        .clr (sc_clr),
        .cnt (sc_cnt)
    );

    function automatic vec_t mkv(input logic [4:0] rs, input logic [4:0] rt,
                                 input logic ut, input logic memrd,
                                 input logic [4:0] wn, input logic br,
                                 input logic [1:0] mem, input logic ack,
                                 input logic [7:0] eo, input logic [15:0] ec,
                                 input logic ee);
        vec_t v;
        v.rs = rs; v.rt = rt; v.ut = ut; v.memrd = memrd; v.wn = wn;
        v.br = br; v.mem = mem; v.ack = ack;
        v.exp_out = eo; v.exp_cnt = ec; v.exp_err = ee;
        return v;
    endfunction

    function automatic logic [7:0] outs();
        return {bus.dmem_req, bus.en_pc, bus.en_ifid, bus.en_idex,
                bus.en_exmem, bus.en_memwb, bus.flush_ifid, bus.flush_idex};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.id_rs      = v.rs;
        bus.id_rt      = v.rt;
        bus.id_uses_rt = v.ut;
        bus.idex_memrd = v.memrd;
        bus.idex_wn    = v.wn;
        bus.br_taken   = v.br;
        bus.exmem_mem  = v.mem;
        bus.dmem_ack   = v.ack;
    endtask

    initial begin
        //          rs  rt  ut memrd wn br mem    ack  out     cnt err
        vt[0]  = mkv(0,  0,  0, 0,    0, 0, 2'b00, 0, O_IDLE, 0,  0); // INIT
        vt[1]  = mkv(0,  0,  0, 0,    0, 0, 2'b00, 0, O_FREE, 0,  0);
        vt[2]  = mkv(8,  0,  0, 1,    8, 0, 2'b00, 0, O_LU,   0,  0); // rs load-use
        vt[3]  = mkv(0,  0,  0, 0,    0, 0, 2'b00, 0, O_FREE, 1,  0);
        vt[4]  = mkv(0,  0,  0, 1,    0, 0, 2'b00, 0, O_FREE, 1,  0); // wn=$0
        vt[5]  = mkv(3,  9,  0, 1,    9, 0, 2'b00, 0, O_FREE, 1,  0); // rt, not used
        vt[6]  = mkv(3,  9,  1, 1,    9, 0, 2'b00, 0, O_LU,   1,  0); // rt, used
        vt[7]  = mkv(0,  0,  0, 0,    0, 0, 2'b00, 0, O_FREE, 2,  0);
        vt[8]  = mkv(0,  0,  0, 0,    0, 0, 2'b10, 0, O_MSTL, 2,  0); // load miss
        vt[9]  = mkv(0,  0,  0, 0,    0, 0, 2'b10, 0, O_MSTL, 3,  0);
        vt[10] = mkv(0,  0,  0, 0,    0, 0, 2'b10, 0, O_MSTL, 4,  0);
        vt[11] = mkv(0,  0,  0, 0,    0, 0, 2'b10, 1, O_ZW,   5,  0); // ack
        vt[12] = mkv(0,  0,  0, 0,    0, 0, 2'b00, 0, O_FREE, 5,  0);
        vt[13] = mkv(0,  0,  0, 0,    0, 0, 2'b01, 1, O_ZW,   5,  0); // zero-wait
        vt[14] = mkv(8,  0,  0, 1,    8, 1, 2'b00, 0, O_BR,   5,  0); // br + LU
        vt[15] = mkv(0,  0,  0, 0,    0, 0, 2'b00, 1, O_FREE, 5,  0); // stray ack
        vt[16] = mkv(0,  0,  0, 0,    0, 1, 2'b10, 0, O_MSTL, 5,  0); // mem > br
        vt[17] = mkv(8,  0,  0, 1,    8, 1, 2'b10, 1, O_ZWBR, 6,  0);
        vt[18] = mkv(0,  0,  0, 0,    0, 0, 2'b00, 0, O_FREE, 6,  0);
        vt[19] = mkv(0,  0,  0, 0,    0, 0, 2'b01, 0, O_MSTL, 6,  0); // no ack
        vt[20] = mkv(0,  0,  0, 0,    0, 0, 2'b01, 0, O_MSTL, 7,  0);
        vt[21] = mkv(0,  0,  0, 0,    0, 0, 2'b01, 0, O_MSTL, 8,  0);
        vt[22] = mkv(0,  0,  0, 0,    0, 0, 2'b01, 0, O_MSTL, 9,  0);
        vt[23] = mkv(0,  0,  0, 0,    0, 0, 2'b01, 0, O_FREE, 10, 0); // timeout
        vt[24] = mkv(0,  0,  0, 0,    0, 0, 2'b00, 0, O_FREE, 10, 1);

        drive(vt[0]);
        #2;
        check("reset_outs", int'(outs()), int'(O_IDLE));
        check("reset_cnt", int'(bus.stall_cnt), 0);
        check("reset_err", int'(bus.mem_err), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        for (int i = 0; i < 25; i++) begin
            drive(vt[i]);
            #4;
            check($sformatf("v%0d_outs", i), int'(outs()), int'(vt[i].exp_out));
            check($sformatf("v%0d_cnt", i), int'(bus.stall_cnt), int'(vt[i].exp_cnt));
            check($sformatf("v%0d_err", i), int'(bus.mem_err), int'(vt[i].exp_err));
            @(posedge clk);
            #1;
        end

        // Reset asserted while waiting on memory
        drive(mkv(0, 0, 0, 0, 0, 0, 2'b10, 0, O_MSTL, 0, 0));
        @(posedge clk); #1;
        check("mw_req_before", int'(bus.dmem_req), 1);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check("mw_rst_req", int'(bus.dmem_req), 0);
        check("mw_rst_outs", int'(outs()), int'(O_IDLE));
        check("mw_rst_err", int'(bus.mem_err), 0);
        check("mw_rst_cnt", int'(bus.stall_cnt), 0);
        drive(vt[0]);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rel_init", int'(outs()), int'(O_IDLE));
        @(posedge clk); #1;
        check("rel_run", int'(outs()), int'(O_FREE));
        check("rel_cnt", int'(bus.stall_cnt), 0);

        // Saturation of a 2-bit sat_counter
        sc_inc = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("sc_two", int'(sc_cnt), 2);
        repeat (3) @(posedge clk);
        #1;
        check("sc_sat", int'(sc_cnt), 3);
        sc_clr = 1'b1;
        @(posedge clk); #1;
        check("sc_clr", int'(sc_cnt), 0);
        sc_clr = 1'b0;
        sc_inc = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
